// File: rtl/sync_unfifo.sv
// Single-clock first-word-fall-through FIFO with full/almost-full/empty flags.
// Optional sticky overflow/underflow flags are built when SYNC_UNFIFO_ERR_FLAGS_EN is defined.
module sync_unfifo #(
    parameter int DSIZE        = 16,
    parameter int ASIZE        = 4,
    parameter int AFULL_MARGIN = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             walmostfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow
);

    localparam int             DEPTH   = 1 << ASIZE;
    localparam logic [ASIZE:0] C_FULL  = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] C_AFULL = (ASIZE+1)'(DEPTH - AFULL_MARGIN);

    logic [DSIZE-1:0] r_mem [DEPTH];
    logic [ASIZE-1:0] r_wptr;
    logic [ASIZE-1:0] r_rptr;
    logic [ASIZE:0]   r_count;

    logic w_wr_acc;
    logic w_rd_acc;

    // Flags come only from the registered count, so no input-to-flag paths exist.
    assign wfull       = (r_count == C_FULL);
    assign rempty      = (r_count == '0);
    assign walmostfull = (r_count >= C_AFULL);
    assign count       = r_count;
    assign rdata       = r_mem[r_rptr];

    assign w_wr_acc = winc && !wfull;
    assign w_rd_acc = rinc && !rempty;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef SYNC_UNFIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (winc && wfull) begin
                r_overflow <= 1'b1;
            end
            if (rinc && rempty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_unfifo.sv
// Directed scoreboard bench for sync_unfifo (default parameters).
module tb_sync_unfifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        winc;
    logic [15:0] wdata;
    logic        wfull;
    logic        walmostfull;
    logic        rinc;
    logic [15:0] rdata;
    logic        rempty;
    logic [4:0]  count;
    logic        overflow;
    logic        underflow;

    sync_unfifo #(.DSIZE(16), .ASIZE(4), .AFULL_MARGIN(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .winc        (winc),
        .wdata       (wdata),
        .wfull       (wfull),
        .walmostfull (walmostfull),
        .rinc        (rinc),
        .rdata       (rdata),
        .rempty      (rempty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [15:0] sb[$];
    int          mcount = 0;
    bit          m_ovf  = 1'b0;
    bit          m_unf  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags();
        bit e_ovf;
        bit e_unf;
`ifdef SYNC_UNFIFO_ERR_FLAGS_EN
        e_ovf = m_ovf;
        e_unf = m_unf;
`else
        e_ovf = 1'b0;
        e_unf = 1'b0;
`endif
        chk("count",       32'(count),       32'(mcount));
        chk("rempty",      32'(rempty),      32'(mcount == 0));
        chk("wfull",       32'(wfull),       32'(mcount == 16));
        chk("walmostfull", 32'(walmostfull), 32'(mcount >= 14));
        chk("overflow",    32'(overflow),    32'(e_ovf));
        chk("underflow",   32'(underflow),   32'(e_unf));
    endtask

    // Called at posedge+1; inputs held for one edge, then model and DUT compared.
    task automatic step(input bit w, input logic [15:0] d, input bit r);
        bit wa;
        bit ra;
        winc  = w;
        wdata = d;
        rinc  = r;
        #2;
        if (r && mcount > 0) chk("rdata", 32'(rdata), 32'(sb[0]));
        wa = w && (mcount < 16);
        ra = r && (mcount > 0);
        if (w && mcount == 16) m_ovf = 1'b1;
        if (r && mcount == 0)  m_unf = 1'b1;
        @(posedge clk);
        #1;
        if (wa) sb.push_back(d);
        if (ra) void'(sb.pop_front());
        mcount = sb.size();
        winc = 1'b0;
        rinc = 1'b0;
        check_flags();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        winc  = 1'b1;
        rinc  = 1'b1;
        wdata = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        sb.delete();
        mcount = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        check_flags();
        rst_n = 1'b1;
        winc  = 1'b0;
        rinc  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = '0;
        @(posedge clk);
        #1;
        do_reset();

        // Fill, overflow attempt, then drain.
        for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0);
        step(1'b1, 16'hDEAD, 1'b0);
        step(1'b1, 16'hDEAD, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 16'h0, 1'b1);

        // Simultaneous write+read while empty.
        step(1'b1, 16'h1234, 1'b1);
        chk("rdata_fwft", 32'(rdata), 32'h1234);
        step(1'b0, 16'h0, 1'b1);

        // Sustained read+write at occupancy 3 across pointer wrap.
        for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h0100 + i), 1'b0);
        for (int i = 3; i < 43; i++) step(1'b1, 16'(16'h0100 + i), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1);

        // Reset with data queued.
        for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h0A00 + i), 1'b0);
        do_reset();
        step(1'b1, 16'hBEEF, 1'b0);
        chk("rdata_after_reset", 32'(rdata), 32'hBEEF);
        step(1'b0, 16'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
